// File: rtl/temperature_monitor_pkg.sv
// Shared types and sizing helpers for the multi-channel temperature window monitor.
// The per-channel state struct is sized from the package window geometry below.
package temperature_monitor_pkg;

  localparam int DEF_WIDTH        = 16;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_RESEED_COUNT = 4;

  localparam int PTR_W    = $clog2(DEF_DEPTH);
  localparam int FILL_W   = PTR_W + 1;
  localparam int SUM_W    = DEF_WIDTH + PTR_W;
  localparam int CONSEC_W = $clog2(DEF_RESEED_COUNT + 1);

  function automatic int chW(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int frameW(input int width, input int channels);
    return chW(channels) + width;
  endfunction

  typedef struct packed {
    logic [PTR_W-1:0]    ptr;
    logic [FILL_W-1:0]   fill;
    logic [SUM_W-1:0]    sum;
    logic [CONSEC_W-1:0] consec;
  } chan_state_t;

endpackage

// File: rtl/temperature_serial_receiver.sv
// Synchronises the serial link, shifts frames MSB first and emits one-cycle frameValid.
// Optional partial-frame timeout is enabled by TEMPERATURE_FRAME_TIMEOUT_EN.
module temperature_serial_receiver
  import temperature_monitor_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int CHANNELS       = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sda_i,
  input  logic                       scl_i,
  output logic                       frameValid_o,
  output logic [chW(CHANNELS)-1:0]   frameId_o,
  output logic [WIDTH-1:0]           frameValue_o
);

  localparam int CH_W    = chW(CHANNELS);
  localparam int FRAME_W = frameW(WIDTH, CHANNELS);
  localparam int CNT_W   = $clog2(FRAME_W);

  logic               sdaMeta_q, sdaSync_q, sclMeta_q, sclSync_q, sclPrev_q;
  logic [FRAME_W-1:0] shift_q, frameData_q, shift_d;
  logic [CNT_W-1:0]   bitCount_q;
  logic               frameValid_q;
  logic               sclRise, lastBit, timeoutHit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sdaMeta_q <= 1'b0;
      sdaSync_q <= 1'b0;
      sclMeta_q <= 1'b0;
      sclSync_q <= 1'b0;
      sclPrev_q <= 1'b0;
    end else begin
      sdaMeta_q <= sda_i;
      sdaSync_q <= sdaMeta_q;
      sclMeta_q <= scl_i;
      sclSync_q <= sclMeta_q;
      sclPrev_q <= sclSync_q;
    end
  end

  always_comb begin
    sclRise = sclSync_q & ~sclPrev_q;
    shift_d = {shift_q[FRAME_W-2:0], sdaSync_q};
    lastBit = (bitCount_q == CNT_W'(FRAME_W - 1));
  end

`ifdef TEMPERATURE_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] timeout_q;

  assign timeoutHit = (timeout_q == TO_W'(TIMEOUT_CYCLES));

  // Idle-time counter only runs while a frame is partially received.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_q <= '0;
    end else if (sclRise || (bitCount_q == '0)) begin
      timeout_q <= '0;
    end else if (!timeoutHit) begin
      timeout_q <= timeout_q + 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      frameData_q  <= '0;
      bitCount_q   <= '0;
      frameValid_q <= 1'b0;
    end else begin
      frameValid_q <= 1'b0;
      if (sclRise) begin
        shift_q <= shift_d;
        if (lastBit) begin
          bitCount_q   <= '0;
          frameValid_q <= 1'b1;
          frameData_q  <= shift_d;
        end else begin
          bitCount_q <= bitCount_q + 1'b1;
        end
      end else if (timeoutHit) begin
        bitCount_q <= '0;
      end
    end
  end

  assign frameValid_o = frameValid_q;
  assign frameId_o    = frameData_q[FRAME_W-1 -: CH_W];
  assign frameValue_o = frameData_q[WIDTH-1:0];

endmodule

// File: rtl/temperature_window_monitor.sv
// Per-channel sliding-window averager with anomaly flagging and reseed on persistent anomalies.
// Define TEMPERATURE_FRAME_TIMEOUT_EN to discard stalled partial frames in the receiver.
module temperature_window_monitor
  import temperature_monitor_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int CHANNELS       = 4,
  parameter int THRESHOLD      = 64,
  parameter int RESEED_COUNT   = DEF_RESEED_COUNT,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sda,
  input  logic                      scl,
  output logic                      temperatureReady,
  output logic [WIDTH-1:0]          temperature,
  output logic [chW(CHANNELS)-1:0]  channel,
  output logic [WIDTH-1:0]          averageTemperature,
  output logic                      windowFull,
  output logic                      anomaly,
  output logic                      frameError
);

  localparam int CH_W = chW(CHANNELS);

  logic             frameValid;
  logic [CH_W-1:0]  frameId;
  logic [WIDTH-1:0] frameValue;

  temperature_serial_receiver #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) receiver (
    .clk(clk), .reset(reset), .sda_i(sda), .scl_i(scl),
    .frameValid_o(frameValid), .frameId_o(frameId), .frameValue_o(frameValue)
  );

  logic [WIDTH-1:0] history_q [CHANNELS][DEPTH];
  chan_state_t      state_q   [CHANNELS];
  chan_state_t      cur, state_d;

  logic             idValid, fullPre, isAnomaly, reseed, writeEn;
  logic [CH_W-1:0]  chIdx;
  logic [PTR_W-1:0] writePtr;
  logic [WIDTH-1:0] oldest, avgPre, diff;
  logic [CONSEC_W-1:0] consecInc;

  logic             ready_q, error_q, full_q, anomaly_q;
  logic [WIDTH-1:0] temp_q, avg_q;
  logic [CH_W-1:0]  channel_q;

  // Decide the window update for the frame currently leaving the receiver.
  always_comb begin
    idValid   = ({1'b0, frameId} < (CH_W + 1)'(CHANNELS));
    chIdx     = idValid ? frameId : '0;
    cur       = state_q[chIdx];
    oldest    = history_q[chIdx][cur.ptr];
    fullPre   = (cur.fill == FILL_W'(DEPTH));
    avgPre    = cur.sum[SUM_W-1 -: WIDTH];
    diff      = (frameValue >= avgPre) ? (frameValue - avgPre) : (avgPre - frameValue);
    isAnomaly = fullPre && (diff > WIDTH'(THRESHOLD));
    consecInc = cur.consec + 1'b1;
    reseed    = isAnomaly && (consecInc == CONSEC_W'(RESEED_COUNT));
    state_d   = cur;
    writeEn   = 1'b0;
    writePtr  = cur.ptr;
    if (reseed) begin
      writeEn        = 1'b1;
      writePtr       = '0;
      state_d.ptr    = PTR_W'(1);
      state_d.fill   = FILL_W'(1);
      state_d.sum    = SUM_W'(frameValue);
      state_d.consec = '0;
    end else if (isAnomaly) begin
      state_d.consec = consecInc;
    end else begin
      writeEn        = 1'b1;
      state_d.ptr    = cur.ptr + 1'b1;
      state_d.fill   = fullPre ? cur.fill : cur.fill + 1'b1;
      state_d.sum    = cur.sum + SUM_W'(frameValue) - (fullPre ? SUM_W'(oldest) : '0);
      state_d.consec = '0;
    end
  end

  // Commit channel state and register the result in the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= '0;
        for (int d = 0; d < DEPTH; d++) history_q[c][d] <= '0;
      end
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      temp_q    <= '0;
      channel_q <= '0;
      avg_q     <= '0;
      full_q    <= 1'b0;
      anomaly_q <= 1'b0;
    end else begin
      ready_q <= frameValid && idValid;
      error_q <= frameValid && !idValid;
      if (frameValid && idValid) begin
        state_q[chIdx] <= state_d;
        if (writeEn) history_q[chIdx][writePtr] <= frameValue;
        temp_q    <= frameValue;
        channel_q <= frameId;
        avg_q     <= state_d.sum[SUM_W-1 -: WIDTH];
        full_q    <= (state_d.fill == FILL_W'(DEPTH));
        anomaly_q <= isAnomaly;
      end
    end
  end

  assign temperatureReady   = ready_q;
  assign frameError         = error_q;
  assign temperature        = temp_q;
  assign channel            = channel_q;
  assign averageTemperature = avg_q;
  assign windowFull         = full_q;
  assign anomaly            = anomaly_q;

endmodule
